// File: rtl/retire_unit.sv
// retire_unit: in-order retirement buffer with two register-file write ports.
// Entries are allocated at tail, completed out of order by tag, and retired
// from head (up to two per cycle) once done.
// Optional macro RETIRE_CMPL_BYPASS_EN: a same-cycle completion to the head
// (or head+1) entry counts as done for that cycle's retire decision.
module retire_unit #(
   parameter int DEPTH = 8,
   parameter int TAG_W = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              alloc_valid,
   input  logic [4:0]        alloc_rd,
   input  logic              alloc_wen,
   output logic              alloc_ready,
   output logic [TAG_W-1:0]  alloc_tag,
   input  logic              cmpl_valid,
   input  logic [TAG_W-1:0]  cmpl_tag,
   input  logic [31:0]       cmpl_data,
   input  logic              flush,
   output logic [4:0]        rd1,
   output logic [31:0]       rd1_data,
   output logic              RegWrite1,
   output logic [4:0]        rd2,
   output logic [31:0]       rd2_data,
   output logic              RegWrite2,
   output logic [1:0]        retire_count,
   output logic              empty,
   output logic [TAG_W:0]    count
);

   localparam logic [TAG_W:0] DEPTH_C = (TAG_W+1)'(DEPTH);

   logic [TAG_W-1:0] head_reg, tail_reg;
   logic [TAG_W:0]   count_reg;
   logic [TAG_W-1:0] head_p1, head_next;
   logic [TAG_W:0]   count_next;

   // per-entry state, gathered for indexed reads
   logic [DEPTH-1:0] valid_vec, done_vec, wen_vec;
   logic [4:0]       rd_arr   [DEPTH];
   logic [31:0]      data_arr [DEPTH];

   logic       alloc_fire;
   logic       byp1, byp2;
   logic       elig1, elig2, retire1, retire2;
   logic [1:0] n_ret;
   logic [31:0] ret_data1, ret_data2;

   assign head_p1     = head_reg + TAG_W'(1);
   assign alloc_ready = (count_reg < DEPTH_C) && !flush;
   assign alloc_tag   = tail_reg;
   assign alloc_fire  = alloc_valid && alloc_ready;
   assign empty       = (count_reg == '0);
   assign count       = count_reg;

`ifdef RETIRE_CMPL_BYPASS_EN
   // a completion landing on head / head+1 this cycle is treated as done now
   assign byp1 = cmpl_valid && (cmpl_tag == head_reg) && valid_vec[head_reg] && !done_vec[head_reg];
   assign byp2 = cmpl_valid && (cmpl_tag == head_p1)  && valid_vec[head_p1]  && !done_vec[head_p1];
`else
   assign byp1 = 1'b0;
   assign byp2 = 1'b0;
`endif

   // retire decision: strictly in order, slot 2 only behind slot 1; flush discards
   always_comb begin
      elig1      = valid_vec[head_reg] && (done_vec[head_reg] || byp1);
      elig2      = elig1 && valid_vec[head_p1] && (done_vec[head_p1] || byp2);
      retire1    = elig1 && !flush;
      retire2    = elig2 && !flush;
      n_ret      = 2'(retire1) + 2'(retire2);
      ret_data1  = byp1 ? cmpl_data : data_arr[head_reg];
      ret_data2  = byp2 ? cmpl_data : data_arr[head_p1];
      head_next  = head_reg + TAG_W'(n_ret);
      count_next = count_reg + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(n_ret);
   end

   // pointer and occupancy registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else if (flush) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else begin
         head_reg  <= head_next;
         tail_reg  <= alloc_fire ? tail_reg + TAG_W'(1) : tail_reg;
         count_reg <= count_next;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic        v_reg, d_reg, w_reg;
         logic [4:0]  r_reg;
         logic [31:0] dat_reg;
         logic        alloc_here, clear_here, cmpl_here;

         assign alloc_here = alloc_fire && (tail_reg == TAG_W'(gi));
         assign clear_here = (retire1 && (head_reg == TAG_W'(gi))) ||
                             (retire2 && (head_p1  == TAG_W'(gi)));
         assign cmpl_here  = cmpl_valid && (cmpl_tag == TAG_W'(gi)) && v_reg && !d_reg;

         // entry lifecycle: allocate -> complete -> retire (clear); flush wipes
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               v_reg   <= 1'b0;
               d_reg   <= 1'b0;
               w_reg   <= 1'b0;
               r_reg   <= '0;
               dat_reg <= '0;
            end else if (flush) begin
               v_reg <= 1'b0;
               d_reg <= 1'b0;
            end else if (alloc_here) begin
               v_reg <= 1'b1;
               d_reg <= 1'b0;
               w_reg <= alloc_wen;
               r_reg <= alloc_rd;
            end else if (clear_here) begin
               v_reg <= 1'b0;
               d_reg <= 1'b0;
            end else if (cmpl_here) begin
               d_reg   <= 1'b1;
               dat_reg <= cmpl_data;
            end
         end

         assign valid_vec[gi] = v_reg;
         assign done_vec[gi]  = d_reg;
         assign wen_vec[gi]   = w_reg;
         assign rd_arr[gi]    = r_reg;
         assign data_arr[gi]  = dat_reg;
      end
   endgenerate

   // registered write ports: zero whenever the slot does not retire
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd1          <= '0;
         rd1_data     <= '0;
         RegWrite1    <= 1'b0;
         rd2          <= '0;
         rd2_data     <= '0;
         RegWrite2    <= 1'b0;
         retire_count <= '0;
      end else begin
         rd1          <= retire1 ? rd_arr[head_reg] : 5'd0;
         rd1_data     <= retire1 ? ret_data1 : 32'd0;
         RegWrite1    <= retire1 && wen_vec[head_reg] && (rd_arr[head_reg] != 5'd0);
         rd2          <= retire2 ? rd_arr[head_p1] : 5'd0;
         rd2_data     <= retire2 ? ret_data2 : 32'd0;
         RegWrite2    <= retire2 && wen_vec[head_p1] && (rd_arr[head_p1] != 5'd0);
         retire_count <= n_ret;
      end
   end

endmodule
